multi_key_process: RTL and testbench
====================================

// Module: multi_key_process
// PURPOSE
//  N-channel push-button front end: per-key 2-flop synchroniser, debounce, and single-cycle event
//  pulses (press, short, long, auto-repeat, release). Sits between raw board buttons and UI/control logic.
//  Successor to the single-key processor: adds reset, N channels, ms-based timing, repeat mode and polarity.
// PARAMETERS
//  N_KEYS       4           number of independent key channels (>=1)
//  IN_C_HZ      50_000_000  clk frequency; must be a multiple of 1000 (elaboration assert)
//  DEBOUNCE_MS  10          stable time before the debounced level changes (>=1)
//  LONG_MS      500         hold time from press event to long event (> DEBOUNCE_MS)
//  REPEAT_MS    100         auto-repeat period after long event (>=1)
//  ACTIVE_HIGH  1           1: in_key=1 means pressed; 0: in_key=0 means pressed
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous, active-low reset
//  in_key       in   N_KEYS  raw asynchronous button inputs
//  repeat_en    in   N_KEYS  per-channel auto-repeat enable (synchronous to clk)
//  key_level    out  N_KEYS  debounced level, 1 = pressed
//  out_press    out  N_KEYS  1-cycle pulse on debounced press
//  out_short    out  N_KEYS  1-cycle pulse on release before long event
//  out_long     out  N_KEYS  1-cycle pulse LONG_CYC cycles after out_press, key still held
//  out_repeat   out  N_KEYS  1-cycle pulse every REPEAT_CYC while held after long, repeat_en=1
//  out_release  out  N_KEYS  1-cycle pulse on every debounced release
// BEHAVIOUR
//  - Cycles: X_CYC = X_MS*(IN_C_HZ/1000). Counter widths $clog2(X_CYC+1); no wrap, counters saturate.
//  - Reset: all outputs 0, sync flops and key_level = released, FSM IDLE, all counters 0.
//  - Sync: in_key normalised by ACTIVE_HIGH, then 2 flops (s1, s2). repeat_en not synchronised.
//  - Debounce: counter increments while s2 != key_level, clears on any cycle s2 == key_level;
//    key_level toggles after DEBOUNCE_CYC consecutive differing cycles. A stable input change is
//    seen on key_level at rising edge DEBOUNCE_CYC+2 (first edge sampling new value = edge 1).
//    Bounces shorter than DEBOUNCE_CYC produce no event.
//  - Per-channel FSM IDLE -> HELD -> LONG -> IDLE:
//    IDLE: key_level rise -> out_press, hold counter cleared -> HELD.
//    HELD: hold counter +1/cycle; reaching LONG_CYC -> out_long -> LONG, repeat counter cleared.
//          key_level fall first -> out_short + out_release -> IDLE.
//    LONG: repeat counter counts only while repeat_en=1 (cleared while 0); on REPEAT_CYC -> out_repeat,
//          counter restarts. key_level fall -> out_release only (no short, no repeat that cycle) -> IDLE.
//  - Event pulses registered, asserted on the same edge key_level changes (press/short/release).
//  - Channels fully independent; simultaneous events on multiple channels all reported same cycle.
//  - rst_n mid-operation: outputs drop immediately (async); a key still held after reset release
//    is re-detected as a fresh press via full sync+debounce path.
// STRUCTURE
//  - Package key_pkg: typedef enum {IDLE, HELD, LONG} key_state_t; function ms2cyc(ms, hz).
//  - Sub-module key_channel (one channel: sync, debounce, FSM, counters); top is a generate loop
//    of N_KEYS instances plus parameter asserts.
// TESTING  (IN_C_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5 -> 1 ms = 1 cycle; edges counted from stimulus)
//  - Glitch: key0 high 3 cycles then low -> key_level, all pulses stay 0.
//  - Short: key0 high 10 cycles -> out_press edge 6; out_short+out_release edge 16; no out_long.
//  - Long+repeat: key0 high 40 cycles, repeat_en=1 -> press 6, long 26, repeat 31,36,41;
//    release edge 46 with out_release only, no short.
//  - Repeat off: same as above with repeat_en=0 -> press 6, long 26, release 46, no out_repeat.
//  - Multi-channel: key0 short (10) and key2 long (40) start same cycle -> both press at edge 6,
//    key0 short at 16, key2 long at 26; no cross-channel interference.
//  - Reset: key1 held, rst_n low at edge 15 for 5 cycles -> outputs 0 at once; after release key1
//    still held -> out_press 6 edges after rst_n deasserts. Bounce: 3-cycle low dip mid-hold ignored.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-key push-button front end.
package key_pkg;

   // Per-channel event FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } key_state_t;

   // Convert a millisecond duration to clock cycles.
   function automatic int unsigned ms2cyc(input int unsigned ms, input int unsigned hz);
      return ms * (hz / 1000);
   endfunction

endpackage

// File: rtl/multi_key_process_if.sv
// Key bus: raw buttons and repeat enables in, debounced level and event pulses out.
interface multi_key_process_if #(
   parameter int unsigned N_KEYS = 4
);
   logic [N_KEYS-1:0] in_key;
   logic [N_KEYS-1:0] repeat_en;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] out_press;
   logic [N_KEYS-1:0] out_short;
   logic [N_KEYS-1:0] out_long;
   logic [N_KEYS-1:0] out_repeat;
   logic [N_KEYS-1:0] out_release;

   modport master (
      output in_key, repeat_en,
      input  key_level, out_press, out_short, out_long, out_repeat, out_release
   );

   modport slave (
      input  in_key, repeat_en,
      output key_level, out_press, out_short, out_long, out_repeat, out_release
   );
endinterface

// File: rtl/key_channel.sv
// One key channel: 2-flop sync, debounce, and press/short/long/repeat/release events.
module key_channel
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned LONG_CYC     = 20,
   parameter int unsigned REPEAT_CYC   = 5,
   parameter bit          ACTIVE_HIGH  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_key,
   input  logic repeat_en,
   output logic key_level,
   output logic out_press,
   output logic out_short,
   output logic out_long,
   output logic out_repeat,
   output logic out_release
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned LG_W  = $clog2(LONG_CYC + 1);
   localparam int unsigned RP_W  = $clog2(REPEAT_CYC + 1);

   logic            raw;
   logic            s1_q, s2_q;
   logic            level_q, level_d;
   logic [DB_W-1:0] db_q, db_d;
   logic [LG_W-1:0] hold_q, hold_d;
   logic [RP_W-1:0] rep_q, rep_d;
   key_state_t      state_q, state_d;
   logic            toggle, rise, fall;
   logic            press_d, short_d, long_d, repeat_d, release_d;
   logic            press_q, short_q, long_q, repeat_q, release_q;

   // Normalise so that 1 always means pressed.
   assign raw = ACTIVE_HIGH ? in_key : ~in_key;

   // Debounce: level flips after DEBOUNCE_CYC consecutive cycles disagreeing with it.
   always_comb begin
      db_d    = db_q;
      level_d = level_q;
      toggle  = 1'b0;
      if (s2_q == level_q) begin
         db_d = '0;
      end else if (db_q == DB_W'(DEBOUNCE_CYC - 1)) begin
         db_d    = '0;
         level_d = s2_q;
         toggle  = 1'b1;
      end else begin
         db_d = db_q + 1'b1;
      end
   end

   assign rise = toggle & s2_q;
   assign fall = toggle & ~s2_q;

   // Event FSM; a release always wins over long/repeat in the same cycle.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      rep_d     = rep_q;
      press_d   = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               press_d = 1'b1;
               hold_d  = '0;
               state_d = HELD;
            end
         end
         HELD: begin
            if (fall) begin
               short_d   = 1'b1;
               release_d = 1'b1;
               state_d   = IDLE;
            end else if (hold_q == LG_W'(LONG_CYC - 1)) begin
               long_d  = 1'b1;
               rep_d   = '0;
               state_d = LONG;
            end else if (hold_q < LG_W'(LONG_CYC)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         LONG: begin
            if (fall) begin
               release_d = 1'b1;
               state_d   = IDLE;
            end else if (!repeat_en) begin
               rep_d = '0;
            end else if (rep_q == RP_W'(REPEAT_CYC - 1)) begin
               repeat_d = 1'b1;
               rep_d    = '0;
            end else begin
               rep_d = rep_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         level_q   <= 1'b0;
         db_q      <= '0;
         hold_q    <= '0;
         rep_q     <= '0;
         state_q   <= IDLE;
         press_q   <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= raw;
         s2_q      <= s1_q;
         level_q   <= level_d;
         db_q      <= db_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         state_q   <= state_d;
         press_q   <= press_d;
         short_q   <= short_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         release_q <= release_d;
      end
   end

   assign key_level   = level_q;
   assign out_press   = press_q;
   assign out_short   = short_q;
   assign out_long    = long_q;
   assign out_repeat  = repeat_q;
   assign out_release = release_q;

endmodule

// File: rtl/multi_key_process.sv
// N-channel push-button front end: independent key_channel per input.
module multi_key_process
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS      = 4,
   parameter int unsigned IN_C_HZ     = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned LONG_MS     = 500,
   parameter int unsigned REPEAT_MS   = 100,
   parameter bit          ACTIVE_HIGH = 1'b1
) (
   input logic                 clk,
   input logic                 rst_n,
   multi_key_process_if.slave  keys
);

   localparam int unsigned DEBOUNCE_CYC = ms2cyc(DEBOUNCE_MS, IN_C_HZ);
   localparam int unsigned LONG_CYC     = ms2cyc(LONG_MS, IN_C_HZ);
   localparam int unsigned REPEAT_CYC   = ms2cyc(REPEAT_MS, IN_C_HZ);

   // Parameter sanity checks at elaboration.
   if (N_KEYS < 1) begin : g_bad_n
      $error("N_KEYS must be >= 1");
   end
   if (IN_C_HZ % 1000 != 0 || IN_C_HZ == 0) begin : g_bad_hz
      $error("IN_C_HZ must be a non-zero multiple of 1000");
   end
   if (DEBOUNCE_MS < 1 || REPEAT_MS < 1) begin : g_bad_ms
      $error("DEBOUNCE_MS and REPEAT_MS must be >= 1");
   end
   if (LONG_MS <= DEBOUNCE_MS) begin : g_bad_long
      $error("LONG_MS must exceed DEBOUNCE_MS");
   end

   // One fully independent channel per key.
   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC),
         .REPEAT_CYC   (REPEAT_CYC),
         .ACTIVE_HIGH  (ACTIVE_HIGH)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_key      (keys.in_key[i]),
         .repeat_en   (keys.repeat_en[i]),
         .key_level   (keys.key_level[i]),
         .out_press   (keys.out_press[i]),
         .out_short   (keys.out_short[i]),
         .out_long    (keys.out_long[i]),
         .out_repeat  (keys.out_repeat[i]),
         .out_release (keys.out_release[i])
      );
   end

endmodule

// File: tb/tb_multi_key_process.sv
// Directed bench for multi_key_process with 1 ms = 1 cycle timing.
module tb_multi_key_process;
   localparam int NK = 4;
   // Event type indices into the log arrays.
   localparam int EV_PRESS = 0, EV_SHORT = 1, EV_LONG = 2, EV_REPEAT = 3, EV_RELEASE = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_key_process_if #(.N_KEYS(NK)) kif ();

   multi_key_process #(
      .N_KEYS      (NK),
      .IN_C_HZ     (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (20),
      .REPEAT_MS   (5),
      .ACTIVE_HIGH (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .keys  (kif)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Per-case event log, indexed [event][channel]; edges counted from first stimulus edge.
   int ev_cnt[5][NK];
   int ev_first[5][NK];
   int ev_last[5][NK];
   int ev_sum[5][NK];
   int lvl_seen[NK];

   // Stimulus configuration.
   int hi_start[NK];
   int hi_len[NK];
   int dip_ch, dip_start, dip_len;
   int rst_at, rst_len;
   logic [NK-1:0] rep_cfg;

   task automatic clear_cfg();
      for (int k = 0; k < NK; k++) begin
         hi_start[k] = 1;
         hi_len[k]   = 0;
      end
      dip_ch = -1; dip_start = 0; dip_len = 0;
      rst_at = 0; rst_len = 0;
      rep_cfg = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      kif.in_key = '0;
      kif.repeat_en = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_case(input int ncyc);
      logic [NK-1:0] ev [5];
      logic [NK-1:0] pat;
      for (int t = 0; t < 5; t++)
         for (int k = 0; k < NK; k++) begin
            ev_cnt[t][k] = 0; ev_first[t][k] = 0; ev_last[t][k] = 0; ev_sum[t][k] = 0;
         end
      for (int k = 0; k < NK; k++) lvl_seen[k] = 0;
      for (int e = 1; e <= ncyc; e++) begin
         @(negedge clk);
         for (int k = 0; k < NK; k++) begin
            pat[k] = (e >= hi_start[k]) && (e < hi_start[k] + hi_len[k]) &&
                     !(k == dip_ch && e >= dip_start && e < dip_start + dip_len);
         end
         kif.in_key    = pat;
         kif.repeat_en = rep_cfg;
         if (e == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("async_rst_level", int'(kif.key_level), 0);
            check("async_rst_pulses", int'({kif.out_press, kif.out_short, kif.out_long,
                                             kif.out_repeat, kif.out_release}), 0);
         end
         if (rst_at != 0 && e == rst_at + rst_len) rst_n = 1'b1;
         @(posedge clk);
         #1;
         ev[EV_PRESS]   = kif.out_press;
         ev[EV_SHORT]   = kif.out_short;
         ev[EV_LONG]    = kif.out_long;
         ev[EV_REPEAT]  = kif.out_repeat;
         ev[EV_RELEASE] = kif.out_release;
         for (int t = 0; t < 5; t++)
            for (int k = 0; k < NK; k++)
               if (ev[t][k]) begin
                  ev_cnt[t][k]++;
                  if (ev_first[t][k] == 0) ev_first[t][k] = e;
                  ev_last[t][k] = e;
                  ev_sum[t][k] += e;
               end
         for (int k = 0; k < NK; k++)
            if (kif.key_level[k]) lvl_seen[k]++;
      end
   endtask

   initial begin
      kif.in_key = '0;
      kif.repeat_en = '0;
      clear_cfg();
      do_reset();
      #1;
      check("reset_level", int'(kif.key_level), 0);
      check("reset_pulses", int'({kif.out_press, kif.out_short, kif.out_long,
                                  kif.out_repeat, kif.out_release}), 0);

      // Glitch: 3 high cycles never reach the debounced level.
      clear_cfg(); hi_len[0] = 3;
      do_reset(); run_case(20);
      check("glitch_level", lvl_seen[0], 0);
      check("glitch_press", ev_cnt[EV_PRESS][0], 0);
      check("glitch_release", ev_cnt[EV_RELEASE][0], 0);

      // Short press.
      clear_cfg(); hi_len[0] = 10;
      do_reset(); run_case(40);
      check("short_press_edge", ev_first[EV_PRESS][0], 6);
      check("short_press_cnt", ev_cnt[EV_PRESS][0], 1);
      check("short_short_edge", ev_first[EV_SHORT][0], 16);
      check("short_release_edge", ev_first[EV_RELEASE][0], 16);
      check("short_long_cnt", ev_cnt[EV_LONG][0], 0);

      // Long press with auto-repeat; release at 46 suppresses a would-be repeat.
      clear_cfg(); hi_len[0] = 40; rep_cfg = 4'b0001;
      do_reset(); run_case(60);
      check("lr_press_edge", ev_first[EV_PRESS][0], 6);
      check("lr_long_edge", ev_first[EV_LONG][0], 26);
      check("lr_repeat_cnt", ev_cnt[EV_REPEAT][0], 3);
      check("lr_repeat_first", ev_first[EV_REPEAT][0], 31);
      check("lr_repeat_sum", ev_sum[EV_REPEAT][0], 31 + 36 + 41);
      check("lr_release_edge", ev_first[EV_RELEASE][0], 46);
      check("lr_release_cnt", ev_cnt[EV_RELEASE][0], 1);
      check("lr_short_cnt", ev_cnt[EV_SHORT][0], 0);

      // Long press with repeat disabled.
      clear_cfg(); hi_len[0] = 40;
      do_reset(); run_case(60);
      check("nr_press_edge", ev_first[EV_PRESS][0], 6);
      check("nr_long_edge", ev_first[EV_LONG][0], 26);
      check("nr_repeat_cnt", ev_cnt[EV_REPEAT][0], 0);
      check("nr_release_edge", ev_first[EV_RELEASE][0], 46);

      // Two channels in parallel.
      clear_cfg(); hi_len[0] = 10; hi_len[2] = 40;
      do_reset(); run_case(60);
      check("mc_k0_press", ev_first[EV_PRESS][0], 6);
      check("mc_k2_press", ev_first[EV_PRESS][2], 6);
      check("mc_k0_short", ev_first[EV_SHORT][0], 16);
      check("mc_k0_long_cnt", ev_cnt[EV_LONG][0], 0);
      check("mc_k2_long", ev_first[EV_LONG][2], 26);
      check("mc_k2_short_cnt", ev_cnt[EV_SHORT][2], 0);
      check("mc_k2_release", ev_first[EV_RELEASE][2], 46);
      check("mc_k1_press_cnt", ev_cnt[EV_PRESS][1], 0);
      check("mc_k3_press_cnt", ev_cnt[EV_PRESS][3], 0);

      // Mid-hold reset on key1; still held afterwards so it re-presses.
      clear_cfg(); hi_len[1] = 40; rst_at = 15; rst_len = 5;
      do_reset(); run_case(60);
      check("rst_press_cnt", ev_cnt[EV_PRESS][1], 2);
      check("rst_press_first", ev_first[EV_PRESS][1], 6);
      check("rst_press_again", ev_last[EV_PRESS][1], 25);
      check("rst_long_edge", ev_first[EV_LONG][1], 45);
      check("rst_release_cnt", ev_cnt[EV_RELEASE][1], 1);
      check("rst_release_edge", ev_first[EV_RELEASE][1], 46);

      // 3-cycle dip during the hold is ignored.
      clear_cfg(); hi_len[0] = 30; dip_ch = 0; dip_start = 10; dip_len = 3;
      do_reset(); run_case(50);
      check("bn_press_cnt", ev_cnt[EV_PRESS][0], 1);
      check("bn_short_cnt", ev_cnt[EV_SHORT][0], 0);
      check("bn_long_edge", ev_first[EV_LONG][0], 26);
      check("bn_release_cnt", ev_cnt[EV_RELEASE][0], 1);
      check("bn_release_edge", ev_first[EV_RELEASE][0], 36);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
